io_dma: RTL and testbench
=========================

# io_dma

Bus-initiator engine for the 16-bit data / 12-bit address peripheral bus (addr, write data, write enable, registered read data). It moves a block of words from a source address to a destination address as read-then-write pairs, so the core can offload GPIO sampling, GPIO playback and RAM-to-IO copies. It drives the same bus port that the core's load/store unit drives toward the IO responder, through the existing bus mux.

## Interface
- DW, 16, data width
- AW, 12, address width; also the width of the length counter
- clk  in  1  clock
- rst  in  1  synchronous reset, active high
- start  in  1  one-cycle request; sampled only in IDLE
- abort  in  1  synchronous cancel; highest priority after rst
- src_addr  in  AW  first source address, sampled with start
- dst_addr  in  AW  first destination address, sampled with start
- len  in  AW  word count, sampled with start; 0 is legal
- src_inc  in  1  1 = source address increments per word, 0 = fixed (port polling)
- dst_inc  in  1  1 = destination address increments per word, 0 = fixed
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse on normal completion
- m_addr  out  AW  bus address
- m_wdata  out  DW  bus write data (to responder din)
- m_we  out  1  bus write enable, active high
- m_rdata  in  DW  bus read data (from responder dout); valid the cycle after a read address is presented with m_we=0

## Operation
- Reset (rst=1): state IDLE, busy=0, done=0, m_we=0, m_addr=0, m_wdata=0; internal address and count registers cleared. Reset mid-transfer discards the transfer; no done.
- States: IDLE, RD, WR.
- IDLE: m_we=0, m_addr=0, m_wdata=0. On start with len!=0: latch src, dst, len, inc flags; go to RD. On start with len=0: no bus cycles; done=1 for one cycle next cycle, stay IDLE.
- RD: m_addr=current src, m_we=0, m_wdata=0. Always go to WR.
- WR: m_addr=current dst, m_we=1, m_wdata=m_rdata (combinational pass-through; responder holds dout while m_we=1). On exit: count-1; src+=src_inc, dst+=dst_inc, both mod 2^AW (0xFFF wraps to 0x000). If count becomes 0: go to IDLE, done=1 next cycle. Otherwise go to RD.
- start while busy: ignored; the latched parameters do not change.
- abort while busy: next state IDLE, no done. A WR cycle that is on the bus in the abort cycle still completes its write. abort in IDLE has no effect. abort and start together in IDLE: abort wins and start is ignored.
- busy=1 exactly in RD and WR.

## Timing
- Start sampled at edge E0. RD for word 0 is on the bus in cycle 1 and WR in cycle 2. Word k: RD in cycle 2k+1, WR in cycle 2k+2.
- Length N: 2N bus cycles. done=1 and busy=0 in cycle 2N+1. A new start is accepted in cycle 2N+1.
- len=0: done=1 in cycle 1, busy stays 0.
- Throughput: 1 word per 2 cycles. No wait states; the responder has a fixed 1-cycle read latency.
- busy, done and the state are registered. m_addr and m_we decode from state. m_wdata is combinational from m_rdata in WR only.

## Structure
- Shared package io_pkg holds the state encoding (IDLE, RD, WR) and the IO map constants GPI_A=12'h000 and GPO_A=12'h001, which the IO responder also uses.
- Single module with no sub-module. Contents: a 2-bit state register, three AW-bit registers (src, dst, count) and two flag registers.

## Test plan
- RAM copy: src=0x100, dst=0x200, len=4, both inc; RAM holds 0x1111, 0x2222, 0x3333, 0x4444 -> writes land at 0x200..0x203 in order, done at cycle 9, busy high for cycles 1-8.
- GPIO playback: RAM 0x010..0x012 = 0xA5A5, 0x5A5A, 0xFFFF; dst=0x001 fixed, src inc, len=3 -> gpio_out shows the three values on consecutive WR edges, then holds 0xFFFF.
- GPIO sampling: src=0x000 fixed, dst=0x300 inc, len=2, gpio_in changed each cycle -> RAM 0x300 and 0x301 receive the responder's registered samples with 1-cycle latency.
- Boundaries: len=0 gives done in cycle 1 and no m_we ever. src=0xFFE, len=3 reads 0xFFE, 0xFFF, 0x000. start pulsed mid-transfer is ignored.
- Abort after the second WR of len=8: exactly 2 writes occur, no done, busy=0 the next cycle, and a fresh start is then accepted.
- rst asserted in an RD cycle: all outputs are 0 the next cycle, no write is issued, and no done.

Source files
------------

// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared state encoding and IO map for the peripheral bus
package io_pkg;

  localparam int IO_DW = 16;
  localparam int IO_AW = 12;

  // IO map shared with the IO responder
  localparam logic [IO_AW-1:0] GPI_A = 12'h000;
  localparam logic [IO_AW-1:0] GPO_A = 12'h001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

endpackage

// File: rtl/io_dma_if.sv
// rtl/io_dma_if.sv - peripheral bus port between an initiator and the IO responder
interface io_dma_if #(
  parameter int DW = 16,
  parameter int AW = 12
) ();

  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_we;
  logic [DW-1:0] m_rdata;

  modport master (
    output m_addr,
    output m_wdata,
    output m_we,
    input  m_rdata
  );

  modport slave (
    input  m_addr,
    input  m_wdata,
    input  m_we,
    output m_rdata
  );

endinterface

// File: rtl/io_dma.sv
// rtl/io_dma.sv - block copy engine issuing read-then-write pairs on the peripheral bus
module io_dma
  import io_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [AW-1:0] len,
  input  logic          src_inc,
  input  logic          dst_inc,
  output logic          busy,
  output logic          done,
  io_dma_if.master      bus
);

  state_t        state_q;
  state_t        state_d;
  logic          done_d;
  logic          accept;
  logic [AW-1:0] src_q;
  logic [AW-1:0] dst_q;
  logic [AW-1:0] cnt_q;
  logic          src_inc_q;
  logic          dst_inc_q;

  // A request is only taken in IDLE and loses to a simultaneous abort
  assign accept = (state_q == IDLE) && start && !abort;

  // Next-state and completion decode
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (len != '0) begin
            state_d = RD;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RD: begin
        state_d = abort ? IDLE : WR;
      end
      WR: begin
        // The write on the bus this cycle completes even when aborted
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q == AW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = RD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, busy and done registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != IDLE);
      done    <= done_d;
    end
  end

  // Transfer parameters: latched on accept, stepped as each write leaves the bus
  always_ff @(posedge clk) begin
    if (rst) begin
      src_q     <= '0;
      dst_q     <= '0;
      cnt_q     <= '0;
      src_inc_q <= 1'b0;
      dst_inc_q <= 1'b0;
    end else if (accept && (len != '0)) begin
      src_q     <= src_addr;
      dst_q     <= dst_addr;
      cnt_q     <= len;
      src_inc_q <= src_inc;
      dst_inc_q <= dst_inc;
    end else if (state_q == WR) begin
      cnt_q <= cnt_q - AW'(1);
      src_q <= src_q + AW'(src_inc_q);
      dst_q <= dst_q + AW'(dst_inc_q);
    end
  end

  // Bus drive decoded from state; write data passes the responder's read data straight through
  always_comb begin
    bus.m_addr  = '0;
    bus.m_we    = 1'b0;
    bus.m_wdata = '0;
    case (state_q)
      RD: begin
        bus.m_addr = src_q;
      end
      WR: begin
        bus.m_addr  = dst_q;
        bus.m_we    = 1'b1;
        bus.m_wdata = bus.m_rdata;
      end
      default: begin
        bus.m_addr = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_io_dma.sv
// tb/tb_io_dma.sv - self-checking bench for io_dma with a RAM/GPIO responder and a word-level copy model
module tb_io_dma;
  import io_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [11:0] src_addr = '0;
  logic [11:0] dst_addr = '0;
  logic [11:0] len = '0;
  logic        src_inc = 1'b0;
  logic        dst_inc = 1'b0;
  logic        busy;
  logic        done;

  io_dma_if #(.DW(16), .AW(12)) bus ();

  io_dma #(.DW(16), .AW(12)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .len      (len),
    .src_inc  (src_inc),
    .dst_inc  (dst_inc),
    .busy     (busy),
    .done     (done),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Responder: RAM plus GPIO, registered read data held while a write is on the bus
  logic [15:0] mem [0:4095];
  logic [15:0] rdata_q;
  logic [15:0] gpio_out;
  logic [15:0] gpio_in = 16'h0BAD;
  logic        ld_en = 1'b0;
  logic [11:0] ld_addr = '0;
  logic [15:0] ld_data = '0;

  always @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
      if (ld_addr == GPO_A) gpio_out <= ld_data;
    end else if (bus.m_we) begin
      if (bus.m_addr == GPO_A) gpio_out <= bus.m_wdata;
      else if (bus.m_addr != GPI_A) mem[bus.m_addr] <= bus.m_wdata;
    end
    if (!bus.m_we)
      rdata_q <= (bus.m_addr == GPI_A) ? gpio_in :
                 (bus.m_addr == GPO_A) ? gpio_out : mem[bus.m_addr];
  end
  assign bus.m_rdata = rdata_q;

  // Bus monitor: logs reads, writes and done pulses mid-cycle
  logic [11:0] wr_a [0:255];
  logic [15:0] wr_d [0:255];
  logic [11:0] rd_a [0:255];
  int wr_cnt = 0;
  int rd_cnt = 0;
  int done_cnt = 0;

  always @(negedge clk) begin
    if (bus.m_we) begin
      wr_a[wr_cnt[7:0]] <= bus.m_addr;
      wr_d[wr_cnt[7:0]] <= bus.m_wdata;
      wr_cnt <= wr_cnt + 1;
    end else if (busy) begin
      rd_a[rd_cnt[7:0]] <= bus.m_addr;
      rd_cnt <= rd_cnt + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  // Reference model: address space as an array, copy applied word by word
  logic [15:0] ref_mem [0:4095];
  logic [15:0] ref_gpo;
  logic [11:0] exp_a [0:63];
  logic [15:0] exp_d [0:63];
  logic [11:0] exp_r [0:63];

  int checks = 0;
  int errors = 0;

  function automatic logic [15:0] ref_rd(input logic [11:0] a);
    if (a == GPI_A) return gpio_in;
    if (a == GPO_A) return ref_gpo;
    return ref_mem[a];
  endfunction

  task automatic ref_wr(input logic [11:0] a, input logic [15:0] v);
    if (a == GPO_A) ref_gpo = v;
    else if (a != GPI_A) ref_mem[a] = v;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model the first n words of a transfer into exp_* and the reference memory
  task automatic model_xfer(input logic [11:0] s, input logic [11:0] d, input int n,
                            input logic si, input logic di);
    logic [11:0] sa;
    logic [11:0] da;
    logic [15:0] v;
    for (int k = 0; k < n; k++) begin
      sa = si ? 12'(s + 12'(k)) : s;
      da = di ? 12'(d + 12'(k)) : d;
      v = ref_rd(sa);
      exp_r[k] = sa;
      exp_a[k] = da;
      exp_d[k] = v;
      ref_wr(da, v);
    end
  endtask

  task automatic chk_log(input string tag, input int wbase, input int rbase, input int n);
    chk({tag, "_nwr"}, 32'(wr_cnt - wbase), 32'(n));
    chk({tag, "_nrd"}, 32'(rd_cnt - rbase), 32'(n));
    for (int k = 0; k < n; k++) begin
      chk({tag, "_raddr"}, 32'(rd_a[8'(rbase + k)]), 32'(exp_r[k]));
      chk({tag, "_waddr"}, 32'(wr_a[8'(wbase + k)]), 32'(exp_a[k]));
      chk({tag, "_wdata"}, 32'(wr_d[8'(wbase + k)]), 32'(exp_d[k]));
    end
  endtask

  // Full transfer with timing checks; optional start pulse mid-transfer that must be ignored
  task automatic run_xfer(input string tag, input logic [11:0] s, input logic [11:0] d,
                          input logic [11:0] n, input logic si, input logic di,
                          input bit mid_start);
    int wbase, rbase, dbase, busy_n, done_at;
    logic busy_at_done;
    wbase = wr_cnt;
    rbase = rd_cnt;
    dbase = done_cnt;
    model_xfer(s, d, int'(n), si, di);
    src_addr = s; dst_addr = d; len = n; src_inc = si; dst_inc = di;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_n = 0;
    done_at = 0;
    busy_at_done = 1'b1;
    for (int c = 1; c <= 2 * int'(n) + 6; c++) begin
      if (busy) busy_n++;
      if (done && done_at == 0) begin
        done_at = c;
        busy_at_done = busy;
      end
      if (mid_start && c == 3) begin
        start = 1'b1; src_addr = ~s; dst_addr = ~d; len = 12'd7;
      end
      if (mid_start && c == 4) start = 1'b0;
      @(negedge clk);
    end
    chk({tag, "_done_cycle"}, 32'(done_at), 32'(2 * int'(n) + 1));
    chk({tag, "_busy_cycles"}, 32'(busy_n), 32'(2 * int'(n)));
    chk({tag, "_busy_at_done"}, 32'(busy_at_done), 32'(0));
    chk({tag, "_done_pulses"}, 32'(done_cnt - dbase), 32'(1));
    chk_log(tag, wbase, rbase, int'(n));
  endtask

  initial begin
    int wbase, rbase, dbase;
    logic [15:0] v;
    logic [11:0] rs, rdst, rn;

    // Preload RAM (and the GPO register) while the DUT is held in reset
    ref_gpo = '0;
    for (int a = 0; a < 4096; a++) begin
      case (a)
        12'h100: v = 16'h1111;
        12'h101: v = 16'h2222;
        12'h102: v = 16'h3333;
        12'h103: v = 16'h4444;
        12'h010: v = 16'hA5A5;
        12'h011: v = 16'h5A5A;
        12'h012: v = 16'hFFFF;
        default: v = 16'($urandom);
      endcase
      ref_mem[a] = v;
      if (a == 1) ref_gpo = v;
      ld_en = 1'b1; ld_addr = 12'(a); ld_data = v;
      @(negedge clk);
    end
    ld_en = 1'b0;
    @(negedge clk);

    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_addr", 32'(bus.m_addr), 32'(0));
    chk("rst_we", 32'(bus.m_we), 32'(0));
    chk("rst_wdata", 32'(bus.m_wdata), 32'(0));
    rst = 1'b0;
    @(negedge clk);

    // RAM-to-RAM copy
    run_xfer("copy", 12'h100, 12'h200, 12'd4, 1'b1, 1'b1, 1'b0);

    // GPIO playback to the fixed output port
    run_xfer("play", 12'h010, GPO_A, 12'd3, 1'b1, 1'b0, 1'b0);
    chk("play_gpio_out", 32'(gpio_out), 32'h0000FFFF);

    // GPIO sampling: input changes every cycle, RD samples land one cycle later
    wbase = wr_cnt;
    dbase = done_cnt;
    src_addr = GPI_A; dst_addr = 12'h300; len = 12'd2; src_inc = 1'b0; dst_inc = 1'b1;
    gpio_in = 16'h9000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      gpio_in = 16'h9000 + 16'(c);
      @(negedge clk);
    end
    chk("samp_nwr", 32'(wr_cnt - wbase), 32'(2));
    chk("samp_addr0", 32'(wr_a[8'(wbase)]), 32'h300);
    chk("samp_data0", 32'(wr_d[8'(wbase)]), 32'h9001);
    chk("samp_addr1", 32'(wr_a[8'(wbase + 1)]), 32'h301);
    chk("samp_data1", 32'(wr_d[8'(wbase + 1)]), 32'h9003);
    chk("samp_done", 32'(done_cnt - dbase), 32'(1));
    ref_wr(12'h300, 16'h9001);
    ref_wr(12'h301, 16'h9003);
    gpio_in = 16'hC0DE;

    // Zero length: done in cycle 1, no bus cycles
    run_xfer("len0", 12'h123, 12'h456, 12'd0, 1'b1, 1'b1, 1'b0);

    // Source address wraps through the top of the map
    run_xfer("wrap", 12'hFFE, 12'h800, 12'd3, 1'b1, 1'b1, 1'b0);

    // Start pulsed mid-transfer is ignored
    run_xfer("midstart", 12'h180, 12'h900, 12'd3, 1'b1, 1'b1, 1'b1);

    // Abort during the second WR: that write completes, nothing further
    wbase = wr_cnt;
    rbase = rd_cnt;
    dbase = done_cnt;
    model_xfer(12'h600, 12'h700, 2, 1'b1, 1'b1);
    src_addr = 12'h600; dst_addr = 12'h700; len = 12'd8; src_inc = 1'b1; dst_inc = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_in_wr", 32'(bus.m_we), 32'(1));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'(0));
    repeat (6) @(negedge clk);
    chk("abort_done", 32'(done_cnt - dbase), 32'(0));
    chk_log("abort", wbase, rbase, 2);
    run_xfer("after_abort", 12'h640, 12'hA00, 12'd2, 1'b0, 1'b1, 1'b0);

    // Reset during RD: outputs clear, no write, no done
    wbase = wr_cnt;
    dbase = done_cnt;
    src_addr = 12'h400; dst_addr = 12'h500; len = 12'd4; src_inc = 1'b1; dst_inc = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rstrd_busy_before", 32'(busy), 32'(1));
    rst = 1'b1;
    @(negedge clk);
    chk("rstrd_busy", 32'(busy), 32'(0));
    chk("rstrd_done", 32'(done), 32'(0));
    chk("rstrd_addr", 32'(bus.m_addr), 32'(0));
    chk("rstrd_we", 32'(bus.m_we), 32'(0));
    chk("rstrd_wdata", 32'(bus.m_wdata), 32'(0));
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("rstrd_nwr", 32'(wr_cnt - wbase), 32'(0));
    chk("rstrd_nodone", 32'(done_cnt - dbase), 32'(0));

    // Randomized transfers against the model
    for (int i = 0; i < 6; i++) begin
      rs = 12'($urandom_range(16, 4095));
      rdst = 12'($urandom_range(16, 4095));
      rn = 12'($urandom_range(1, 7));
      run_xfer("rand", rs, rdst, rn, 1'($urandom), 1'($urandom), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
